// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package divider_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_addsub.sv
// Combinational N-bit adder/subtractor: computes A + B, or A - B when i_sub is set.
module div_addsub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_sum
);

  logic [N-1:0] w_b;

  assign w_b   = i_b ^ {N{i_sub}};
  assign o_sum = i_a + w_b + N'(i_sub);

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are registered on entry to DONE and held until the next completion.
module restoring_divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_dvs;
  logic              r_busy;
  logic              r_done;
  logic              r_dbz;
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;

  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_trial;
  logic [WIDTH-1:0]  w_rem_next;
  logic [WIDTH-1:0]  w_quo_next;
  logic              w_last;

  // Partial remainder stays below the divisor, so its stored form needs only WIDTH bits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  div_addsub #(
    .N(WIDTH + 1)
  ) u_addsub (
    .i_a  (w_shift),
    .i_b  ({1'b0, r_dvs}),
    .i_sub(1'b1),
    .o_sum(w_trial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (divisor == '0) begin
              r_state     <= StDone;
              r_done      <= 1'b1;
              r_dbz       <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend;
            end else begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
              r_quo   <= dividend;
              r_dvs   <= divisor;
              r_rem   <= '0;
              r_cnt   <= '0;
            end
          end
        end
        StCalc: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) begin
            r_state     <= StDone;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_dbz       <= 1'b0;
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed self-checking bench for restoring_divider_seq at WIDTH=4.
module tb_restoring_divider_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;

  restoring_divider_seq #(
    .WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; issues one start and waits (bounded) for done, sampling at negedges.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, output logic [3:0] q,
                        output logic [3:0] r, output logic z, output int lat,
                        output int busy_cnt, output logic overlap);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    overlap  = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] q, r;
    logic z, ov;
    int lat, bc;
    do_div(4'd13, 4'd3, q, r, z, lat, bc, ov);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 5", lat);
    end
    checks++;
    if ({q, r, z} !== {4'd4, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%b, want q=4 r=1 dbz=0", q, r, z);
    end
    checks++;
    if (bc !== 4 || ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy_cycles=%0d overlap=%b, want 4 and 0", bc, ov);
    end
  endtask

  task automatic test_values();
    logic [3:0] q, r;
    logic z, ov;
    int lat, bc;
    do_div(4'd15, 4'd1, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r} !== {4'd15, 4'd0} || lat !== 5) begin
      errors++;
      $display("FAIL div_15_1: got q=%0d r=%0d lat=%0d, want q=15 r=0 lat=5", q, r, lat);
    end
    do_div(4'd0, 4'd7, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r} !== {4'd0, 4'd0}) begin
      errors++;
      $display("FAIL div_0_7: got q=%0d r=%0d, want q=0 r=0", q, r);
    end
    do_div(4'd5, 4'd9, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r} !== {4'd0, 4'd5}) begin
      errors++;
      $display("FAIL div_small_5_9: got q=%0d r=%0d, want q=0 r=5", q, r);
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] q, r;
    logic z, ov;
    int lat, bc;
    do_div(4'd9, 4'd0, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r, z} !== {4'd15, 4'd9, 1'b1} || lat !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL div_zero_9_0: got q=%0d r=%0d dbz=%b lat=%0d busy=%0d, want 15 9 1 1 0",
               q, r, z, lat, bc);
    end
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_hold: got dbz=%b, want 1", div_by_zero);
    end
    do_div(4'd6, 4'd4, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r, z} !== {4'd1, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL div_zero_clear_6_4: got q=%0d r=%0d dbz=%b, want q=1 r=2 dbz=0", q, r, z);
    end
  endtask

  // start stays high; operands change every cycle. Only the IDLE-cycle values must be used.
  task automatic test_start_held();
    int done_cnt;
    done_cnt = 0;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (k == 5) begin
        checks++;
        if (done !== 1'b1 || {quotient, remainder} !== {4'd4, 4'd1}) begin
          errors++;
          $display("FAIL held_first: got done=%b q=%0d r=%0d, want 1 4 1", done, quotient,
                   remainder);
        end
      end else if (k >= 6 && k <= 10) begin
        checks++;
        if (done !== 1'b0 || {quotient, remainder} !== {4'd4, 4'd1}) begin
          errors++;
          $display("FAIL held_hold_k%0d: got done=%b q=%0d r=%0d, want 0 4 1", k, done,
                   quotient, remainder);
        end
      end else if (k == 11) begin
        checks++;
        if (done !== 1'b1 || {quotient, remainder} !== {4'd2, 4'd3}) begin
          errors++;
          $display("FAIL held_second: got done=%b q=%0d r=%0d, want 1 2 3", done, quotient,
                   remainder);
        end
      end
      if (k == 11) begin
        start = 1'b0;
      end else begin
        dividend = 4'(k + 5);
        divisor  = 4'((k % 4) + 2);
      end
    end
    checks++;
    if (done_cnt !== 2) begin
      errors++;
      $display("FAIL held_done_count: got %0d, want 2", done_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    logic [3:0] q, r;
    logic z, ov;
    int lat, bc;
    int done_cnt;
    do_div(4'd9, 4'd0, q, r, z, lat, bc, ov);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_calc: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    do_div(4'd7, 4'd2, q, r, z, lat, bc, ov);
    checks++;
    if ({q, r, z} !== {4'd3, 4'd1, 1'b0} || lat !== 5) begin
      errors++;
      $display("FAIL rst_then_7_2: got q=%0d r=%0d dbz=%b lat=%0d, want 3 1 0 5", q, r, z, lat);
    end
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL rst_spurious_done: got %0d pulses, want 0", done_cnt);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] q, r;
    logic z, ov;
    int lat, bc;
    int bad;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), q, r, z, lat, bc, ov);
        checks++;
        if (b == 0) begin
          if (q !== 4'd15 || r !== 4'(a) || z !== 1'b1 || lat !== 1) begin
            errors++;
            bad++;
            if (bad < 10)
              $display("FAIL exh_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want 15 %0d 1 1",
                       a, b, q, r, z, lat, a);
          end
        end else if ((int'(q) * b + int'(r)) != a || int'(r) >= b || z !== 1'b0 || lat !== 5
                     || ov !== 1'b0) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL exh_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d",
                     a, b, q, r, z, lat, a / b, a % b);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_values();
    test_div_zero();
    test_start_held();
    test_reset_mid_calc();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider_seq.md
RESTORING_DIVIDER_SEQ -- requirements
Module: restoring_divider_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result width in bits (≥2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator; captured with start.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator; captured with start.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress (CALC state).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid in the same cycle.
REQ-009 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port: div_by_zero  output  1  flags that the last result came from divisor==0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 and divisor!=0: SHALL capture operands, clear partial remainder and counter, go to CALC.
REQ-014 In IDLE with start=1 and divisor==0: SHALL go directly to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1.
REQ-015 In CALC, SHALL perform exactly one restoring step per cycle, for WIDTH cycles.
REQ-016 Each step SHALL: shift {R,Q} left by one (R is WIDTH+1 bits, MSB of Q enters R LSB); trial = R + ~{0,divisor} + 1.
REQ-017 If trial MSB==0, SHALL set R=trial and Q LSB=1; otherwise SHALL keep R and set Q LSB=0.
REQ-018 After the WIDTH-th step, SHALL go to DONE.
REQ-019 Latency: start sampled at edge N; done high during cycle N+WIDTH+1 (cycle N+1 for divide-by-zero).
REQ-020 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 quotient/remainder/div_by_zero SHALL update only on entry to DONE and hold until the next DONE.
REQ-022 div_by_zero SHALL be cleared by the next completed nonzero-divisor division.
REQ-023 start SHALL be ignored in CALC and DONE; operand changes during CALC SHALL not affect the result.
REQ-024 start asserted in the same cycle that done is high SHALL be ignored (DONE is not IDLE).
REQ-025 dividend < divisor SHALL yield quotient=0, remainder=dividend.
REQ-026 busy SHALL be high exactly in CALC; busy and done SHALL never be high together.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; counter and internal R/Q cleared.
REQ-028 Reset asserted mid-CALC SHALL abort the division with no done pulse; after deassertion the block SHALL accept a new start in the first clock.

Structure
REQ-029 State encoding (IDLE/CALC/DONE) and the default WIDTH SHALL live in a shared package divider_pkg.
REQ-030 The trial subtraction SHALL be a separate combinational sub-module div_addsub: WIDTH+1-bit adder with B inverted and carry-in 1 under a sub control.
REQ-031 Iteration counter SHALL be $clog2(WIDTH+1) bits wide; no other sub-modules.

Verification (WIDTH=4)
REQ-032 start, dividend=13, divisor=3 -> done 5 cycles later, quotient=4, remainder=1, div_by_zero=0; busy high 4 cycles.
REQ-033 start, dividend=15, divisor=1 -> quotient=15, remainder=0; then dividend=0, divisor=7 -> quotient=0, remainder=0.
REQ-034 start, dividend=9, divisor=0 -> done next cycle, quotient=15, remainder=9, div_by_zero=1; next 6/4 -> quotient=1, remainder=2, div_by_zero=0.
REQ-035 start held high continuously with changing operands -> only IDLE-cycle operands used; results hold between done pulses.
REQ-036 rst pulsed during 2nd CALC cycle -> no done, all outputs 0 immediately; new start 7/2 -> quotient=3, remainder=1.
REQ-037 Exhaustive all 256 operand pairs -> quotient*divisor+remainder==dividend and remainder<divisor for divisor!=0.
